txt_arb: RTL and testbench

//  Arbitrates the single-port text-page RAM ($400-$7FF, 1 KiB) between two requesters.
//  - Video scanout fetch: the text renderer walking txt_adr.
//  - CPU read/write port.

---
 rtl/txt_arb.sv | 187 ++++++++++++++++++
 tb/tb_txt_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txt_arb.sv
// ---------------------------------------------------------------------------
// txt_arb -- arbiter for the single-port 1 KiB text-page RAM.
//
// Two requesters share the RAM:
//   * video scanout fetch (read-only, normally wins, fully pipelined)
//   * CPU read/write port (at most one outstanding read). A starvation
//     counter lets the CPU override video after MAX_WAIT denied cycles.
//
// Ports
//   clk                  system clock, all logic on posedge
//   res                  asynchronous active-low reset
//   vid_req/vid_adr      video fetch request and byte address
//   vid_gnt              combinational grant (accept = vid_req & vid_gnt)
//   vid_vld/vid_q        one-cycle read-data pulse and held data
//   cpu_req/we/adr/d     CPU access request, direction, address, write data
//   cpu_gnt              combinational grant (accept = cpu_req & cpu_gnt)
//   cpu_ack/cpu_q        one-cycle completion pulse and held read data
//   mem_adr/mem_d/mem_we registered RAM address, write data, write enable
//   mem_q                RAM read data, sampled RD_LAT cycles after the
//                        accept edge that registered mem_adr
// ---------------------------------------------------------------------------
module txt_arb #(
  parameter logic [15:0] BASE     = 16'h0400,
  parameter int          AW       = 10,
  parameter int          RD_LAT   = 1,
  parameter int          MAX_WAIT = 4,
  parameter logic [7:0]  FILL     = 8'hA0
) (
  input  logic          clk,
  input  logic          res,
  input  logic          vid_req,
  input  logic [15:0]   vid_adr,
  output logic          vid_gnt,
  output logic          vid_vld,
  output logic [7:0]    vid_q,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:0]   cpu_adr,
  input  logic [7:0]    cpu_d,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [7:0]    cpu_q,
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_d,
  output logic          mem_we,
  input  logic [7:0]    mem_q
);

  // Counter is at least one bit wide so MAX_WAIT = 0 still elaborates;
  // with MAX_WAIT = 0 it simply never leaves zero and the CPU always wins.
  localparam int              WW     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WMAX   = WW'(MAX_WAIT);
  // Window bounds in 17 bits so BASE + 2**AW cannot wrap.
  localparam logic [16:0]     WIN_LO = {1'b0, BASE};
  localparam logic [16:0]     WIN_HI = WIN_LO + (17'd1 << AW);

  logic [WW-1:0]   r_wait_cnt;
  logic            r_cpu_busy;
  logic            r_cpu_ack;
  logic            r_vid_vld;
  logic [7:0]      r_vid_q;
  logic [7:0]      r_cpu_q;
  logic [AW-1:0]   r_mem_adr;
  logic [7:0]      r_mem_d;
  logic            r_mem_we;
  // Read-tag shift pipe: valid, owner (1 = CPU), address was in window.
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_cpu;
  logic [RD_LAT-1:0] r_tag_win;

  logic          w_cpu_elig;
  logic          w_cpu_win;
  logic          w_cpu_acc;
  logic          w_vid_acc;
  logic          w_acc;
  logic          w_acc_rd;
  logic [15:0]   w_acc_adr;
  logic          w_acc_win;
  logic [AW-1:0] w_acc_off;
  logic          w_ret_vld;
  logic          w_ret_cpu;
  logic [7:0]    w_ret_dat;

  // ---------------- arbitration ----------------
  // A CPU read stays blocked while outstanding and during its ack cycle.
  assign w_cpu_elig = cpu_req & ~r_cpu_busy & ~r_cpu_ack;
  assign w_cpu_win  = w_cpu_elig & (~vid_req | (r_wait_cnt == WMAX));

  // Grants are forced low while reset is held so nothing looks accepted.
  assign cpu_gnt   = w_cpu_win & res;
  assign vid_gnt   = vid_req & ~w_cpu_win & res;

  assign w_cpu_acc = cpu_gnt;
  assign w_vid_acc = vid_gnt;
  assign w_acc     = w_cpu_acc | w_vid_acc;
  assign w_acc_rd  = w_vid_acc | (w_cpu_acc & ~cpu_we);

  assign w_acc_adr = w_cpu_acc ? cpu_adr : vid_adr;
  assign w_acc_win = ({1'b0, w_acc_adr} >= WIN_LO) && ({1'b0, w_acc_adr} < WIN_HI);
  assign w_acc_off = AW'(w_acc_adr - BASE);

  // ---------------- starvation counter ----------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_wait_cnt <= '0;
    end else if (w_cpu_elig & ~w_cpu_win) begin
      if (r_wait_cnt != WMAX) r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // ---------------- RAM request registers ----------------
  // Out-of-window accepts leave the RAM untouched: address holds, no write.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_mem_adr <= '0;
      r_mem_d   <= '0;
      r_mem_we  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_acc & w_acc_win) begin
        r_mem_adr <= w_acc_off;
        if (w_cpu_acc & cpu_we) begin
          r_mem_we <= 1'b1;
          r_mem_d  <= cpu_d;
        end
      end
    end
  end

  // ---------------- read-tag pipe ----------------
  // The tag leaving the last stage lines up with mem_q for that read.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_tag_vld <= '0;
      r_tag_cpu <= '0;
      r_tag_win <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_cpu[i] <= r_tag_cpu[i-1];
        r_tag_win[i] <= r_tag_win[i-1];
      end
      r_tag_vld[0] <= w_acc_rd;
      r_tag_cpu[0] <= w_cpu_acc;
      r_tag_win[0] <= w_acc_win;
    end
  end

  assign w_ret_vld = r_tag_vld[RD_LAT-1];
  assign w_ret_cpu = r_tag_cpu[RD_LAT-1];
  assign w_ret_dat = r_tag_win[RD_LAT-1] ? mem_q : FILL;

  // ---------------- completion / return data ----------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_vid_vld  <= 1'b0;
      r_vid_q    <= '0;
      r_cpu_ack  <= 1'b0;
      r_cpu_q    <= '0;
      r_cpu_busy <= 1'b0;
    end else begin
      r_vid_vld <= w_ret_vld & ~w_ret_cpu;
      // Writes complete one cycle after accept; reads when their tag returns.
      r_cpu_ack <= (w_ret_vld & w_ret_cpu) | (w_cpu_acc & cpu_we);
      if (w_ret_vld & ~w_ret_cpu) r_vid_q <= w_ret_dat;
      if (w_ret_vld &  w_ret_cpu) r_cpu_q <= w_ret_dat;
      // Busy drops on the same edge that raises the ack, so the ack cycle
      // itself is what keeps a new CPU request out for one more cycle.
      if (w_cpu_acc & ~cpu_we) begin
        r_cpu_busy <= 1'b1;
      end else if (w_ret_vld & w_ret_cpu) begin
        r_cpu_busy <= 1'b0;
      end
    end
  end

  assign vid_vld = r_vid_vld;
  assign vid_q   = r_vid_q;
  assign cpu_ack = r_cpu_ack;
  assign cpu_q   = r_cpu_q;
  assign mem_adr = r_mem_adr;
  assign mem_d   = r_mem_d;
  assign mem_we  = r_mem_we;

endmodule

// File: tb/tb_txt_arb.sv
// ---------------------------------------------------------------------------
// tb_txt_arb -- self-checking bench for txt_arb (RD_LAT = 1, MAX_WAIT = 4).
// The text RAM is modelled with an asynchronous read port and a write on the
// clock edge, which gives the one-cycle mem_adr -> mem_q sampling latency.
// ---------------------------------------------------------------------------
module tb_txt_arb;
  localparam int         RD_LAT   = 1;
  localparam int         MAX_WAIT = 4;
  localparam logic [7:0] FILL     = 8'hA0;

  logic        clk = 1'b0;
  logic        res;
  logic        vid_req, vid_gnt, vid_vld;
  logic [15:0] vid_adr;
  logic [7:0]  vid_q;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_ack;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_d, cpu_q;
  logic [9:0]  mem_adr;
  logic [7:0]  mem_d, mem_q;
  logic        mem_we;

  always #5 clk = ~clk;

  txt_arb #(.BASE(16'h0400), .AW(10), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .FILL(FILL)) dut (
    .clk(clk), .res(res),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_gnt(vid_gnt), .vid_vld(vid_vld), .vid_q(vid_q),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_d(cpu_d),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
    .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
  );

  logic [7:0] ram [0:1023];
  assign mem_q = ram[mem_adr];
  always @(posedge clk) if (mem_we) ram[mem_adr] <= mem_d;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  initial for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One CPU transaction with video idle. lat = cycles from accept cycle to ack.
  task automatic cpu_txn(input logic we, input logic [15:0] adr, input logic [7:0] d,
                         output int lat, output logic [7:0] q,
                         output int we_cnt, output logic [9:0] we_adr);
    int n;
    cpu_we = we; cpu_adr = adr; cpu_d = d; cpu_req = 1'b1;
    lat = -1; q = '0; we_cnt = 0; we_adr = '0; n = 0;
    @(negedge clk);
    while (!cpu_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        we_adr = mem_adr;
      end
      if (cpu_ack && lat < 0) lat = k;
      q = cpu_q;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  d;
    int          lat;
    logic [7:0]  q;       // cpu_q after the transaction (held across writes)
    int          we_cnt;
    logic [9:0]  we_adr;
  } vec_t;

  typedef struct {
    int         due;
    logic       rd;
    logic [7:0] dat;
  } pend_t;

  vec_t       tbl [9];
  pend_t      vq[$];
  pend_t      cq[$];
  logic [7:0] sh [0:1023];
  int         acc_cyc[$];
  logic [7:0] acc_dat[$];

  initial begin
    int lat, wc, gc, ac, got, cnt, streak, off;
    logic [7:0] q, sq;
    logic [9:0] wa, exp_wa;
    logic [7:0] exp_wd;
    bit ev, ec, elig, win, vacc, cacc, inw, exp_we, seen;

    tbl[0] = '{1'b0, 16'h0400, 8'h00, 2, init_val(0),      0, 10'h000};
    tbl[1] = '{1'b1, 16'h07D0, 8'h41, 1, init_val(0),      1, 10'h3D0};
    tbl[2] = '{1'b0, 16'h07D0, 8'h00, 2, 8'h41,            0, 10'h000};
    tbl[3] = '{1'b0, 16'h0800, 8'h00, 2, FILL,             0, 10'h000};
    tbl[4] = '{1'b1, 16'h03FF, 8'h77, 1, FILL,             0, 10'h000};
    tbl[5] = '{1'b0, 16'h03FF, 8'h00, 2, FILL,             0, 10'h000};
    tbl[6] = '{1'b0, 16'h07FF, 8'h00, 2, init_val(10'h3FF),0, 10'h000};
    tbl[7] = '{1'b1, 16'h0400, 8'hC3, 1, init_val(10'h3FF),1, 10'h000};
    tbl[8] = '{1'b0, 16'h0400, 8'h00, 2, 8'hC3,            0, 10'h000};

    // ---------- reset with both requesters active ----------
    res = 1'b0; vid_req = 1'b1; vid_adr = 16'h0400;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0500; cpu_d = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_vid_vld", vid_vld, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_mem_we",  mem_we, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_d",   mem_d, 0);
    chk("rst_vid_q",   vid_q, 0);
    chk("rst_cpu_q",   cpu_q, 0);
    chk("rst_vid_gnt", vid_gnt, 0);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    @(posedge clk); #1;
    res = 1'b1;
    @(negedge clk);
    chk("rel_vid_gnt", vid_gnt, 1);
    chk("rel_cpu_gnt", cpu_gnt, 0);
    @(posedge clk); #1;
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("reset sequence done");

    // ---------- video stream $400..$427 ----------
    vid_req = 1'b1; vid_adr = 16'h0400; cnt = 0; got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (vid_vld) begin
        if (acc_cyc.size() > 0) begin
          chk("vstream_data", vid_q, acc_dat[0]);
          chk("vstream_lat", c - acc_cyc[0], 2);
          void'(acc_cyc.pop_front());
          void'(acc_dat.pop_front());
          got++;
        end else begin
          chk("vstream_extra_vld", vid_vld, 0);
        end
      end
      if (vid_req && vid_gnt) begin
        acc_cyc.push_back(c);
        acc_dat.push_back(init_val(int'(vid_adr) - 16'h0400));
        cnt++;
      end
      @(posedge clk); #1;
      if (cnt < 40) vid_adr = 16'h0400 + 16'(cnt);
      else vid_req = 1'b0;
    end
    chk("vstream_count", got, 40);
    $display("video stream: %0d reads returned", got);

    // ---------- CPU starvation against continuous video ----------
    vid_req = 1'b1; vid_adr = 16'h0400;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h05A8;
    gc = -1; ac = -1; sq = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 4) chk("starve_vid_gnt_before", vid_gnt, 1);
      if (gc > 0 && c == gc + 1) chk("starve_vid_gnt_after", vid_gnt, 1);
      if (cpu_gnt && gc < 0) begin
        gc = c;
        chk("starve_vid_gnt_low", vid_gnt, 0);
      end
      if (cpu_ack && ac < 0) begin
        ac = c;
        sq = cpu_q;
      end
      @(posedge clk); #1;
      if (gc > 0) cpu_req = 1'b0;
    end
    vid_req = 1'b0;
    chk("starve_gnt_cycle", gc, 5);
    chk("starve_ack_cycle", ac, 7);
    chk("starve_q", sq, init_val(10'h1A8));
    $display("starvation: cpu_gnt cycle %0d, cpu_ack cycle %0d", gc, ac);
    repeat (4) @(posedge clk);
    #1;

    // ---------- table-driven CPU transactions ----------
    for (int i = 0; i < 9; i++) begin
      cpu_txn(tbl[i].we, tbl[i].adr, tbl[i].d, lat, q, wc, wa);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_we_cnt", i), wc, tbl[i].we_cnt);
      if (tbl[i].we_cnt > 0) chk($sformatf("tbl%0d_we_adr", i), wa, tbl[i].we_adr);
      $display("cpu %s adr=%h d=%h lat=%0d q=%h", tbl[i].we ? "wr" : "rd", tbl[i].adr, tbl[i].d, lat, q);
    end

    // ---------- CPU write then same-address video read ----------
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h07D0; cpu_d = 8'h5E;
    @(negedge clk);
    chk("wr_rd_cpu_gnt", cpu_gnt, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0; vid_req = 1'b1; vid_adr = 16'h07D0;
    @(negedge clk);
    chk("wr_rd_mem_we", mem_we, 1);
    chk("wr_rd_mem_adr", mem_adr, 10'h3D0);
    chk("wr_rd_cpu_ack", cpu_ack, 1);
    chk("wr_rd_vid_gnt", vid_gnt, 1);
    @(posedge clk); #1;
    vid_req = 1'b0;
    @(negedge clk);
    chk("wr_rd_mem_we_off", mem_we, 0);
    @(negedge clk);
    chk("wr_rd_vid_vld", vid_vld, 1);
    chk("wr_rd_vid_q", vid_q, 8'h5E);
    @(posedge clk); #1;
    $display("write-then-video-read $7D0 vid_q=%h", vid_q);

    // ---------- reset in the middle of a CPU read ----------
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0500;
    @(negedge clk);
    chk("mid_cpu_gnt", cpu_gnt, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    res = 1'b0;
    #2;
    res = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack) seen = 1'b1;
    end
    chk("mid_no_ack", seen, 0);
    @(posedge clk); #1;
    cpu_txn(1'b0, 16'h0501, 8'h00, lat, q, wc, wa);
    chk("mid_after_lat", lat, 2);
    chk("mid_after_q", q, init_val(10'h101));
    $display("mid-flight reset: new read lat=%0d q=%h", lat, q);

    // ---------- randomized traffic against a transaction-level model ----------
    for (int i = 0; i < 1024; i++) sh[i] = ram[i];
    vid_req = 1'b0; cpu_req = 1'b0;
    streak = 0; exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    seen = 1'b0;   // reused as "CPU read outstanding"
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ev = 1'b0; ec = 1'b0;
      if (vq.size() > 0 && vq[0].due == cyc) begin
        ev = 1'b1;
        chk("rnd_vid_q", vid_q, vq[0].dat);
        void'(vq.pop_front());
      end
      if (cq.size() > 0 && cq[0].due == cyc) begin
        ec = 1'b1;
        if (cq[0].rd) begin
          chk("rnd_cpu_q", cpu_q, cq[0].dat);
          seen = 1'b0;
        end
        void'(cq.pop_front());
      end
      chk("rnd_vid_vld", vid_vld, ev);
      chk("rnd_cpu_ack", cpu_ack, ec);
      chk("rnd_mem_we", mem_we, exp_we);
      if (exp_we) begin
        chk("rnd_mem_adr", mem_adr, exp_wa);
        chk("rnd_mem_d", mem_d, exp_wd);
      end
      elig = cpu_req && !seen && !ec;
      win  = elig && (!vid_req || streak == MAX_WAIT);
      chk("rnd_cpu_gnt", cpu_gnt, win);
      chk("rnd_vid_gnt", vid_gnt, vid_req && !win);
      streak = (elig && !win) ? streak + 1 : 0;
      exp_we = 1'b0; vacc = 1'b0; cacc = 1'b0;
      if (win) begin
        cacc = 1'b1;
        inw = (cpu_adr >= 16'h0400) && (cpu_adr < 16'h0800);
        off = int'(cpu_adr) - 16'h0400;
        if (cpu_we) begin
          if (inw) begin
            sh[off] = cpu_d;
            exp_we = 1'b1; exp_wa = 10'(off); exp_wd = cpu_d;
          end
          cq.push_back('{cyc + 1, 1'b0, 8'h00});
        end else begin
          cq.push_back('{cyc + 1 + RD_LAT, 1'b1, inw ? sh[off] : FILL});
          seen = 1'b1;
        end
      end else if (vid_req) begin
        vacc = 1'b1;
        inw = (vid_adr >= 16'h0400) && (vid_adr < 16'h0800);
        off = int'(vid_adr) - 16'h0400;
        vq.push_back('{cyc + 1 + RD_LAT, 1'b1, inw ? sh[off] : FILL});
      end
      @(posedge clk); #1;
      if (!vid_req || vacc) begin
        vid_req = ($urandom_range(0, 3) != 0);
        vid_adr = 16'($urandom_range(16'h0380, 16'h087F));
      end
      if (!cpu_req || cacc) begin
        cpu_req = ($urandom_range(0, 2) == 0);
        cpu_we  = 1'($urandom_range(0, 1));
        cpu_adr = 16'($urandom_range(16'h0380, 16'h087F));
        cpu_d   = 8'($urandom);
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    $display("random traffic done");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
